approx_mul_err_monitor: RTL and testbench

// Downstream checker for the generated approximate multiplier netlists. It consumes each
// (operand word, approximate product) pair over a valid/ready stream and recomputes the

---
 rtl/approx_mon_pkg.sv | 18 +
 rtl/approx_mul_err_monitor_if.sv | 13 +
 rtl/approx_err_calc.sv | 23 ++
 rtl/approx_mul_err_monitor.sv | 169 ++++++++++++++++
 tb/tb_approx_mul_err_monitor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/approx_mon_pkg.sv
// Shared types and arithmetic helpers for the approximate-multiplier error monitor.
package approx_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [31:0] abs_diff(input logic [31:0] x, input logic [31:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  // Add and clamp at max_val; one extra bit catches wrap of the 64-bit sum.
  function automatic logic [63:0] sat_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic [63:0] max_val);
    logic [64:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s > {1'b0, max_val}) ? max_val : s[63:0];
  endfunction

endpackage

// File: rtl/approx_mul_err_monitor_if.sv
// Valid/ready stream carrying one (operand word, approximate product) pair per beat.
interface approx_mul_err_monitor_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4
);
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_in;
  logic [OUT_W-1:0] s_out;

  modport master (output s_valid, output s_in, output s_out, input s_ready);
  modport slave  (input s_valid, input s_in, input s_out, output s_ready);
endinterface

// File: rtl/approx_err_calc.sv
// Combinational reference: exact truncated product, absolute error and threshold flag.
module approx_err_calc
  import approx_mon_pkg::*;
#(
  parameter int A_W   = 2,
  parameter int B_W   = 2,
  parameter int OUT_W = 4,
  parameter int ET    = 2
) (
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [OUT_W-1:0] approx,
  output logic [OUT_W-1:0] exact,
  output logic [OUT_W-1:0] err,
  output logic             viol
);

  // Multiplying in OUT_W bits gives the product modulo 2^OUT_W directly.
  assign exact = OUT_W'(a) * OUT_W'(b);
  assign err   = OUT_W'(abs_diff(32'(exact), 32'(approx)));
  assign viol  = 32'(err) > 32'(ET);

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Streaming error monitor: accepts n_samples beats, checks each against the exact
// product through a 2-stage pipe, and accumulates saturating error statistics.
module approx_mul_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4,
  parameter int ET    = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       n_samples,
  approx_mul_err_monitor_if.slave s,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       viol_cnt,
  output logic [OUT_W-1:0]       max_err,
  output logic [CNT_W+OUT_W-1:0] sum_err,
  output logic [IN_W-1:0]        first_viol_in,
  output logic                   first_viol_vld
);

  localparam int HALF  = IN_W / 2;
  localparam int SUM_W = CNT_W + OUT_W;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] n_reg, n_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             accept;

  logic [OUT_W-1:0] calc_exact, calc_err;
  logic             calc_viol;

  logic             s1_vld_reg;
  logic [IN_W-1:0]  s1_in_reg;
  logic [OUT_W-1:0] s1_exact_reg;
  logic [OUT_W-1:0] s1_err_reg;
  logic             s1_viol_reg;

  logic [CNT_W-1:0] viol_reg;
  logic [OUT_W-1:0] max_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [IN_W-1:0]  fv_in_reg;
  logic             fv_vld_reg;

  // A handshake coinciding with start belongs to the run being abandoned.
  assign accept = s.s_valid && ready_reg && !start;

  approx_err_calc #(
    .A_W   (HALF),
    .B_W   (IN_W - HALF),
    .OUT_W (OUT_W),
    .ET    (ET)
  ) u_calc (
    .a      (s.s_in[HALF-1:0]),
    .b      (s.s_in[IN_W-1:HALF]),
    .approx (s.s_out),
    .exact  (calc_exact),
    .err    (calc_err),
    .viol   (calc_viol)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    n_next     = n_reg;
    if (start) begin
      state_next = RUN;
      acc_next   = '0;
      n_next     = n_samples;
    end else begin
      case (state_reg)
        RUN: begin
          if (accept) acc_next = acc_reg + CNT_W'(1);
          if (acc_reg == n_reg) state_next = DRAIN;
        end
        DRAIN:   if (!s1_vld_reg) state_next = DONE;
        default: state_next = state_reg;
      endcase
    end
    // Registered outputs are derived from next-state so they line up with the state.
    ready_next = (state_next == RUN) && (acc_next < n_next);
    busy_next  = (state_next == RUN) || (state_next == DRAIN);
    done_next  = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      n_reg     <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      n_reg     <= n_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_reg   <= 1'b0;
      s1_in_reg    <= '0;
      s1_exact_reg <= '0;
      s1_err_reg   <= '0;
      s1_viol_reg  <= 1'b0;
    end else begin
      s1_vld_reg <= accept;
      if (accept) begin
        s1_in_reg    <= s.s_in;
        s1_exact_reg <= calc_exact;
        s1_err_reg   <= calc_err;
        s1_viol_reg  <= calc_viol;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_reg   <= '0;
      max_reg    <= '0;
      sum_reg    <= '0;
      fv_in_reg  <= '0;
      fv_vld_reg <= 1'b0;
    end else if (start) begin
      viol_reg   <= '0;
      max_reg    <= '0;
      sum_reg    <= '0;
      fv_in_reg  <= '0;
      fv_vld_reg <= 1'b0;
    end else if (s1_vld_reg) begin
      sum_reg <= SUM_W'(sat_add(64'(sum_reg), 64'(s1_err_reg), 64'(SUM_MAX)));
      if (s1_err_reg > max_reg) max_reg <= s1_err_reg;
      if (s1_viol_reg) begin
        if (viol_reg != CNT_MAX) viol_reg <= viol_reg + CNT_W'(1);
        if (!fv_vld_reg) begin
          fv_in_reg  <= s1_in_reg;
          fv_vld_reg <= 1'b1;
        end
      end
    end
  end

  // The registered exact product is kept for debug probing alongside the error.
  logic [OUT_W-1:0] dbg_exact;
  assign dbg_exact = s1_exact_reg;

  assign s.s_ready      = ready_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign viol_cnt       = viol_reg;
  assign max_err        = max_reg;
  assign sum_err        = sum_reg;
  assign first_viol_in  = fv_in_reg;
  assign first_viol_vld = fv_vld_reg;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Directed self-checking bench for approx_mul_err_monitor (IN_W=4, OUT_W=4, ET=2).
module tb_approx_mul_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n_samples = '0;
  logic        busy, done, first_viol_vld;
  logic [15:0] viol_cnt;
  logic [3:0]  max_err, first_viol_in;
  logic [19:0] sum_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  approx_mul_err_monitor_if #(.IN_W(4), .OUT_W(4)) s_if ();

  approx_mul_err_monitor #(.IN_W(4), .OUT_W(4), .ET(2), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .n_samples      (n_samples),
    .s              (s_if),
    .busy           (busy),
    .done           (done),
    .viol_cnt       (viol_cnt),
    .max_err        (max_err),
    .sum_err        (sum_err),
    .first_viol_in  (first_viol_in),
    .first_viol_vld (first_viol_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    n_samples = n;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [3:0] i, input logic [3:0] o);
    s_if.s_valid = 1'b1;
    s_if.s_in = i;
    s_if.s_out = o;
    step();
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (done) break;
      step();
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_stats(input string tag, input int v, input int mx, input int sm,
                           input int fvin, input int fvv);
    chk({tag, ".viol"}, 32'(viol_cnt), 32'(v));
    chk({tag, ".max"}, 32'(max_err), 32'(mx));
    chk({tag, ".sum"}, 32'(sum_err), 32'(sm));
    chk({tag, ".fvld"}, 32'(first_viol_vld), 32'(fvv));
    if (fvv != 0) chk({tag, ".fvin"}, 32'(first_viol_in), 32'(fvin));
  endtask

  initial begin
    int m_sum, m_max, m_viol, m_fv, m_fvv, acc_seen;
    s_if.s_valid = 1'b0;
    s_if.s_in = '0;
    s_if.s_out = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(s_if.s_ready), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk_stats("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Async reset in the middle of a run with three violations recorded
    do_start(16'd6);
    beat(4'hF, 4'h0);
    beat(4'hF, 4'h0);
    beat(4'hF, 4'h0);
    step();
    step();
    chk("pre_rst.viol", 32'(viol_cnt), 3);
    chk("pre_rst.ready", 32'(s_if.s_ready), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.ready", 32'(s_if.s_ready), 0);
    chk("mid_rst.busy", 32'(busy), 0);
    chk_stats("mid_rst", 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst.busy", 32'(busy), 0);
    chk("post_rst.ready", 32'(s_if.s_ready), 0);

    // Single beat 3*3=9 vs 7 -> err 2, at threshold so no violation
    do_start(16'd1);
    chk("t2.ready", 32'(s_if.s_ready), 1);
    chk("t2.busy", 32'(busy), 1);
    beat(4'hF, 4'h7);
    chk("t2.ready_after", 32'(s_if.s_ready), 0);
    step();
    chk_stats("t2", 0, 2, 2, 0, 0);
    chk("t2.done_early", 32'(done), 0);
    step();
    chk("t2.done", 32'(done), 1);
    chk("t2.busy_end", 32'(busy), 0);

    // Two beats: 9 vs 5 -> err 4 (viol); 2*1=2 vs 0 -> err 2
    do_start(16'd2);
    beat(4'hF, 4'h5);
    beat(4'h6, 4'h0);
    step();
    chk_stats("t3", 1, 4, 6, 4'hF, 1);
    step();
    chk("t3.done", 32'(done), 1);

    // Exhaustive sweep, valid held high for longer than the run
    m_sum = 0; m_max = 0; m_viol = 0; m_fv = 0; m_fvv = 0; acc_seen = 0;
    for (int i = 0; i < 16; i++) begin
      int ex, ap, er;
      ex = ((i % 4) * (i / 4)) % 16;
      ap = (i * 5 + 3) % 16;
      er = (ex > ap) ? ex - ap : ap - ex;
      m_sum += er;
      if (er > m_max) m_max = er;
      if (er > 2) begin
        m_viol++;
        if (m_fvv == 0) begin m_fv = i; m_fvv = 1; end
      end
    end
    do_start(16'd16);
    for (int k = 0; k < 18; k++) begin
      s_if.s_valid = 1'b1;
      s_if.s_in = 4'(k);
      s_if.s_out = 4'((k * 5 + 3) % 16);
      if (k == 0 || k == 15 || k == 16 || k == 17)
        chk($sformatf("t4.ready%0d", k), 32'(s_if.s_ready), (k < 16) ? 32'd1 : 32'd0);
      if (s_if.s_ready) acc_seen++;
      step();
    end
    s_if.s_valid = 1'b0;
    chk("t4.accepted", 32'(acc_seen), 16);
    wait_done("t4.done", 8);
    chk_stats("t4", m_viol, m_max, m_sum, m_fv, m_fvv);

    // Restart mid-run: earlier beats (2*2=4 vs 15, err 11) must vanish
    do_start(16'd8);
    for (int k = 0; k < 5; k++) beat(4'hA, 4'hF);
    chk("t5.pre_viol", 32'(viol_cnt), 4);
    start = 1'b1;
    n_samples = 16'd3;
    s_if.s_valid = 1'b1;
    s_if.s_in = 4'hA;
    s_if.s_out = 4'hF;
    step();
    start = 1'b0;
    s_if.s_valid = 1'b0;
    chk_stats("t5.clr", 0, 0, 0, 0, 0);
    step();
    chk_stats("t5.flush", 0, 0, 0, 0, 0);
    beat(4'hF, 4'h0);   // 9 vs 0 -> 9
    beat(4'h5, 4'h1);   // 1 vs 1 -> 0
    beat(4'hE, 4'h3);   // 6 vs 3 -> 3
    wait_done("t5.done", 8);
    chk_stats("t5", 2, 9, 12, 4'hF, 1);

    // Zero-sample run with a beat offered throughout
    s_if.s_valid = 1'b1;
    s_if.s_in = 4'hF;
    s_if.s_out = 4'h0;
    do_start(16'd0);
    chk("t6.ready", 32'(s_if.s_ready), 0);
    step();
    step();
    chk("t6.done", 32'(done), 1);
    step();
    s_if.s_valid = 1'b0;
    chk_stats("t6", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
